imem_program_loader: RTL and testbench
======================================

Name: imem_program_loader

Overview:
- Writer side of the CPU instruction-memory interface. The core only ever reads instruction memory; this block fills it.
- Accepts a byte stream over a valid/ready handshake from the host/debug link and assembles 17-bit instruction words.
- Writes each word into the 64-entry instruction memory.
- Holds the CPU in reset (cpu_hold) until the whole image has loaded without error.

Parameters:
- INSTR_W, 17, instruction word width.
- ADDR_W, 6, instruction address width.
- DEPTH, 64, number of instruction-memory entries; equals 2**ADDR_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a load.
- in_valid  in  1  byte on in_data is valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte this cycle.
- wr_en  out  1  instruction-memory write strobe.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  INSTR_W  write data.
- cpu_hold  out  1  1 = keep the CPU in reset.
- done  out  1  image loaded successfully.
- error  out  1  load aborted on a format error.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, error=0. All outputs are registered.
- Handshake: a byte is accepted only on a rising edge with in_valid=1 and in_ready=1. in_valid while in_ready=0 is ignored, and the byte is not consumed.
- Stream format:
  - First byte: count N. N=0 means 64; N=1..64 are literal; N>64 is an error.
  - Then N groups of 3 bytes, little-endian: B0 = bits[7:0], B1 = bits[15:8], B2[0] = bit16. B2[7:1] must be 0.
- States and transitions:
  - IDLE: in_ready=0. start -> COUNT.
  - COUNT: in_ready=1. Accept N; N>64 -> ERR, else remaining=N, addr=0 -> B0.
  - B0: in_ready=1. Accept byte -> B1.
  - B1: in_ready=1. Accept byte -> B2.
  - B2: in_ready=1. Accept byte. B2[7:1]!=0 -> ERR with no write; else -> WRITE.
  - WRITE: in_ready=0. wr_en=1 for exactly one cycle with wr_addr=addr and wr_data={B2[0],B1,B0}. Then addr+1 and remaining-1. remaining reaching 0 -> DONE (or CHK, see Optional Feature); else -> B0.
  - DONE: done=1, cpu_hold=0, in_ready=0.
  - ERR: error=1, cpu_hold=1, in_ready=0.
- Write timing: wr_en asserts the cycle after the B2 byte is accepted. Maximum throughput is one instruction per 4 cycles.
- Address wrap: after the write to addr 63, addr wraps to 0. This only occurs when N=64, which finishes at that point, so no overwrite can happen.
- start in DONE or ERR: clears done/error, reasserts cpu_hold, -> COUNT.
- start in any other state is ignored; a load in progress is not restarted.
- cpu_hold is 1 in every state except DONE.
- Memory locations beyond the N loaded are not written and keep their prior contents.
- Reset mid-load: immediate return to IDLE. Partial writes stay in memory, and cpu_hold=1.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, go to state CHK (in_ready=1) and accept one checksum byte.
  - Expected value = XOR of every byte accepted since start, including the count byte.
  - Match -> DONE; mismatch -> ERR.
  - The XOR accumulator clears on start.
- Undefined: no CHK state. The last WRITE goes directly to DONE, and no trailing byte is consumed.

Test Plan:
- Reset then start; stream 02, 34 12 01, FF 00 00 -> writes addr0=0x11234 and addr1=0x000FF, each as a single-cycle wr_en; done=1, cpu_hold=0, error=0.
- Count 00 followed by 64 instructions whose value equals their index -> 64 writes to addr 0..63 with wr_data=index; done=1; no write after addr 63.
- Stream 01, AA BB 02 -> error=1 with no wr_en pulse and cpu_hold=1; a following start plus a valid image -> done=1.
- Count 41 (65) -> error=1 immediately, in_ready=0, no writes.
- in_valid toggled randomly while loading 3 instructions -> the same writes as an uninterrupted stream; start pulses mid-load are ignored; rst low mid-load -> IDLE, cpu_hold=1.
- With LOADER_CHECKSUM_EN: stream 01, 01 02 00, then checksum 02 -> done=1. The same stream with checksum 03 -> error=1, cpu_hold=1.

Source files
------------

// File: rtl/imem_program_loader.sv
// -----------------------------------------------------------------------------
// imem_program_loader
//
// Writer side of the CPU instruction memory. A host/debug link streams bytes
// over a valid/ready handshake; the loader assembles them into INSTR_W-bit
// instruction words and writes them into the DEPTH-entry instruction memory.
// The CPU is held in reset (cpu_hold) until an image has loaded cleanly.
//
// Stream format: one count byte N (0 means DEPTH, N > DEPTH is an error),
// then N little-endian 3-byte words {B2[0], B1, B0}; B2[7:1] must be zero.
//
// Optional feature: define LOADER_CHECKSUM_EN to require one trailing byte
// equal to the XOR of every byte accepted since start (count byte included).
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-low reset
//   start     in   single-cycle request to begin a load (IDLE/DONE/ERR only)
//   in_valid  in   byte on in_data is valid
//   in_data   in   stream byte
//   in_ready  out  loader accepts a byte this cycle
//   wr_en     out  instruction-memory write strobe (one cycle per word)
//   wr_addr   out  write address
//   wr_data   out  write data
//   cpu_hold  out  1 = keep the CPU in reset
//   done      out  image loaded successfully
//   error     out  load aborted on a format error
// -----------------------------------------------------------------------------
module imem_program_loader #(
    parameter int INSTR_W = 17,
    parameter int ADDR_W  = 6,
    parameter int DEPTH   = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [INSTR_W-1:0] wr_data,
    output logic               cpu_hold,
    output logic               done,
    output logic               error
);

    localparam int               CNT_W    = ADDR_W + 1;
    localparam logic [7:0]       MAX_N    = 8'(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_COUNT = 4'd1,
        S_B0    = 4'd2,
        S_B1    = 4'd3,
        S_B2    = 4'd4,
        S_WRITE = 4'd5,
        S_DONE  = 4'd6,
        S_ERR   = 4'd7
`ifdef LOADER_CHECKSUM_EN
        , S_CHK = 4'd8
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [CNT_W-1:0]     rem_q, rem_d;
    logic [7:0]           b0_q, b0_d;
    logic [7:0]           b1_q, b1_d;
    logic                 in_ready_q, in_ready_d;
    logic                 wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [INSTR_W-1:0]   wr_data_q, wr_data_d;
    logic                 cpu_hold_q, cpu_hold_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic                 accept_s;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]           csum_q, csum_d;

    // Running XOR checksum update for one accepted byte.
    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    // in_ready_q always mirrors the current state, so this is the handshake.
    assign accept_s = in_valid & in_ready_q;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        b0_d      = b0_q;
        b1_d      = b1_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d    = csum_q;
        if (accept_s) begin
            csum_d = csum_update(csum_q, in_data);
        end else begin
            csum_d = csum_q;
        end
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_COUNT;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = 8'd0;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            S_COUNT: begin
                if (!accept_s) begin
                    state_d = S_COUNT;
                end else if (in_data > MAX_N) begin
                    state_d = S_ERR;
                end else begin
                    rem_d   = (in_data == 8'd0) ? FULL_CNT : in_data[CNT_W-1:0];
                    addr_d  = '0;
                    state_d = S_B0;
                end
            end
            S_B0: begin
                if (accept_s) begin
                    b0_d    = in_data;
                    state_d = S_B1;
                end else begin
                    state_d = S_B0;
                end
            end
            S_B1: begin
                if (accept_s) begin
                    b1_d    = in_data;
                    state_d = S_B2;
                end else begin
                    state_d = S_B1;
                end
            end
            S_B2: begin
                if (!accept_s) begin
                    state_d = S_B2;
                end else if (in_data[7:1] != 7'd0) begin
                    // Malformed top byte: abort before anything reaches memory.
                    state_d = S_ERR;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = INSTR_W'({in_data[0], b1_q, b0_q});
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                // Address wraps only after the last word of a full image.
                addr_d = addr_q + ADDR_W'(1);
                rem_d  = rem_q - ONE_CNT;
                if (rem_q == ONE_CNT) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_B0;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (!accept_s) begin
                    state_d = S_CHK;
                end else if (in_data == csum_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ERR;
                end
            end
`endif
            default: begin
                state_d = S_ERR;
            end
        endcase

        // Status outputs are decoded from the next state so they register
        // in step with the state itself.
        in_ready_d = (state_d == S_COUNT) || (state_d == S_B0) ||
                     (state_d == S_B1)    || (state_d == S_B2)
`ifdef LOADER_CHECKSUM_EN
                     || (state_d == S_CHK)
`endif
                     ;
        cpu_hold_d = (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERR);
    end

    // State, datapath and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            b0_q       <= 8'd0;
            b1_q       <= 8'd0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            b0_q       <= b0_d;
            b1_q       <= b1_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_program_loader
//
// Directed and randomized bench for imem_program_loader. A stream-level
// reference model parses each byte image (count, 3-byte words, optional
// checksum) into the list of memory writes and the final outcome; observed
// writes are collected at negedge and compared against that list.
// -----------------------------------------------------------------------------
module tb_imem_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [16:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;

    logic [7:0]  stream_q[$];
    logic [22:0] obs_q[$];
    logic [22:0] exp_q[$];
    logic        exp_done;
    logic        exp_err;

    imem_program_loader #(.INSTR_W(17), .ADDR_W(6), .DEPTH(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    // Record every write strobe, sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_en === 1'b1) obs_q.push_back({wr_addr, wr_data});
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Append the checksum byte when the image format requires one.
    task automatic add_csum();
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'd0;
        foreach (stream_q[i]) x ^= stream_q[i];
        stream_q.push_back(x);
`endif
    endtask

    // Build an image: count field, nwords words (random or index), one bad B2 optional.
    task automatic build(input logic [7:0] nfield, input int nwords, input bit rnd, input int bad_idx);
        logic [16:0] w;
        logic [7:0]  b2;
        stream_q.delete();
        stream_q.push_back(nfield);
        for (int i = 0; i < nwords; i++) begin
            w  = rnd ? 17'($urandom) : 17'(i);
            b2 = {7'd0, w[16]};
            if (i == bad_idx) b2[5] = 1'b1;
            stream_q.push_back(w[7:0]);
            stream_q.push_back(w[15:8]);
            stream_q.push_back(b2);
        end
        add_csum();
    endtask

    // Reference model: parse the image into expected writes and outcome.
    task automatic model();
        int         cnt;
        logic [7:0] b0, b1, b2;
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x;
`endif
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (stream_q[0] > 8'd64) begin
            exp_err = 1'b1;
            return;
        end
        cnt = (stream_q[0] == 8'd0) ? 64 : int'(stream_q[0]);
        for (int i = 0; i < cnt; i++) begin
            b0 = stream_q[1 + 3*i];
            b1 = stream_q[2 + 3*i];
            b2 = stream_q[3 + 3*i];
            if (b2[7:1] != 7'd0) begin
                exp_err = 1'b1;
                return;
            end
            exp_q.push_back({6'(i), b2[0], b1, b0});
        end
`ifdef LOADER_CHECKSUM_EN
        x = 8'd0;
        for (int i = 0; i <= 3*cnt; i++) x ^= stream_q[i];
        if (stream_q[1 + 3*cnt] == x) exp_done = 1'b1;
        else                          exp_err  = 1'b1;
`else
        exp_done = 1'b1;
`endif
    endtask

    task automatic kick();
        model();
        obs_q.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Feed up to limit bytes, optionally with random gaps and stray start pulses.
    task automatic drive(input int limit, input bit gaps, input bit starts);
        int idx = 0;
        int cyc = 0;
        bit acc;
        while (idx < limit && cyc < 5000 && !(done || error)) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = stream_q[idx];
            start    = starts ? ($urandom_range(0, 9) == 0) : 1'b0;
            acc      = in_valid && in_ready;
            @(negedge clk);
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic finish_check(input string tag);
        int cyc = 0;
        while (!(done || error) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done"},  32'(done),     32'(exp_done));
        chk({tag, "_error"}, 32'(error),    32'(exp_err));
        chk({tag, "_hold"},  32'(cpu_hold), 32'(!exp_done));
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_nwr"},   32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk({tag, "_wr"}, (i < obs_q.size()) ? 32'(obs_q[i]) : 32'hxxxxxxxx, 32'(exp_q[i]));
        end
    endtask

    task automatic run(input string tag, input bit gaps, input bit starts);
        kick();
        drive(stream_q.size(), gaps, starts);
        finish_check(tag);
    endtask

    initial begin
        int n;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_wren",  32'(wr_en),    32'd0);
        chk("rst_addr",  32'(wr_addr),  32'd0);
        chk("rst_data",  32'(wr_data),  32'd0);
        chk("rst_hold",  32'(cpu_hold), 32'd1);
        chk("rst_done",  32'(done),     32'd0);
        chk("rst_error", 32'(error),    32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Bytes offered in IDLE are ignored.
        in_valid = 1'b1; in_data = 8'h05;
        repeat (3) @(negedge clk);
        chk("idle_ready", 32'(in_ready), 32'd0);
        chk("idle_hold",  32'(cpu_hold), 32'd1);
        in_valid = 1'b0;

        // Two-word image with literal expectations.
        stream_q = '{8'h02, 8'h34, 8'h12, 8'h01, 8'hFF, 8'h00, 8'h00};
        add_csum();
        run("basic", 1'b0, 1'b0);
        chk("basic_w0", (obs_q.size() > 0) ? 32'(obs_q[0]) : 32'hxxxxxxxx, 32'({6'd0, 17'h11234}));
        chk("basic_w1", (obs_q.size() > 1) ? 32'(obs_q[1]) : 32'hxxxxxxxx, 32'({6'd1, 17'h000FF}));

        // No trailing byte is taken once done.
        in_valid = 1'b1; in_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("post_done_ready", 32'(in_ready), 32'd0);
        chk("post_done_done",  32'(done),     32'd1);
        in_valid = 1'b0;

        // Full 64-word image, data = index.
        build(8'h00, 64, 1'b0, -1);
        run("full", 1'b0, 1'b0);

        // Bad B2 then recovery.
        stream_q = '{8'h01, 8'hAA, 8'hBB, 8'h02};
        run("badb2", 1'b0, 1'b0);
        build(8'h02, 2, 1'b1, -1);
        run("recover", 1'b1, 1'b0);

        // Count out of range.
        stream_q = '{8'h41};
        run("cnt65", 1'b0, 1'b0);

        // Three words, random gaps and stray start pulses.
        build(8'h03, 3, 1'b1, -1);
        run("gaps3", 1'b1, 1'b1);

        // Random images, some with a corrupt word.
        for (int k = 0; k < 5; k++) begin
            n = $urandom_range(1, 64);
            build(8'(n), n, 1'b1, (k == 2) ? int'($urandom_range(0, n - 1)) : -1);
            run("rand", 1'b1, 1'b1);
        end

        // Reset in the middle of a load: one write lands, then back to IDLE.
        build(8'h03, 3, 1'b1, -1);
        kick();
        drive(5, 1'b0, 1'b0);
        chk("mid_partial", 32'(obs_q.size()), 32'd1);
        chk("mid_w0", (obs_q.size() > 0) ? 32'(obs_q[0]) : 32'hxxxxxxxx, 32'(exp_q[0]));
        #2 rst = 1'b0;
        #1;
        chk("mid_ready", 32'(in_ready), 32'd0);
        chk("mid_hold",  32'(cpu_hold), 32'd1);
        chk("mid_wren",  32'(wr_en),    32'd0);
        chk("mid_done",  32'(done),     32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_idle_ready", 32'(in_ready), 32'd0);
        build(8'h02, 2, 1'b1, -1);
        run("after_rst", 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        stream_q = '{8'h01, 8'h01, 8'h02, 8'h00, 8'h02};
        run("csum_ok", 1'b0, 1'b0);
        chk("csum_ok_lit", 32'(done), 32'd1);
        stream_q = '{8'h01, 8'h01, 8'h02, 8'h00, 8'h03};
        run("csum_bad", 1'b0, 1'b0);
        chk("csum_bad_lit", 32'(error), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
